// File: rtl/seq_stage_controller.sv
// seq_stage_controller: multi-cycle stage sequencer for the sequential RV64 core.
// Walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB and
// drives the per-stage enables plus the memory request/ready handshakes.
// Optional feature macro: SEQ_TIMEOUT_EN adds a watchdog on memory waits
// that raises the sticky `timeout` flag and parks the FSM in HALT.
module seq_stage_controller #(
  parameter int RET_W          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             alu_en,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_BAD     = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_IW    = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  state_t st_q, st_d;
  logic   is_load, is_branch, is_system, is_legal;
  logic   to_hit;

  assign is_load   = (opcode == OP_LOAD);
  assign is_branch = (opcode == OP_BR);
  assign is_system = (opcode == OP_SYS);
  assign is_legal  = (opcode inside {OP_R, OP_I, OP_RW, OP_IW, OP_LOAD, OP_STORE,
                                     OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS});

  // Stage FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_IDLE;
    else        st_q <= st_d;
  end

  // Next-state selection; a watchdog hit overrides the wait in FETCH/MEM
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:    if (start) st_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready)  st_d = S_DECODE;
        else if (to_hit) st_d = S_HALT;
      end
      S_DECODE:  st_d = (is_system || !is_legal) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (is_load || opcode == OP_STORE) st_d = S_MEM;
        else if (is_branch)                st_d = S_FETCH;
        else                               st_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)  st_d = is_load ? S_WB : S_FETCH;
        else if (to_hit) st_d = S_HALT;
      end
      S_WB:      st_d = S_FETCH;
      S_HALT:    st_d = S_HALT;
      default:   st_d = S_HALT;
    endcase
  end

  // Strobes are pure decodes of the state register and the ready inputs;
  // anything that is not a load in MEM is treated as a store so rd/wr stay exclusive
  always_comb begin
    imem_req = (st_q == S_FETCH);
    ir_we    = (st_q == S_FETCH) && imem_ready;
    alu_en   = (st_q == S_EXECUTE);
    dmem_rd  = (st_q == S_MEM) && is_load;
    dmem_wr  = (st_q == S_MEM) && !is_load;
    rf_we    = (st_q == S_WB);
    pc_we    = (st_q == S_WB)
            || ((st_q == S_EXECUTE) && is_branch)
            || ((st_q == S_MEM) && !is_load && dmem_ready);
    busy     = (st_q != S_IDLE) && (st_q != S_HALT);
    halted   = (st_q == S_HALT);
  end

  assign state = st_q;

  // Sticky illegal-opcode flag, captured on the decode cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               illegal <= 1'b0;
    else if ((st_q == S_DECODE) && !is_legal) illegal <= 1'b1;
  end

  // Retired-instruction counter, one count per PC update, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     retired <= '0;
    else if (pc_we) retired <= retired + 1'b1;
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             wait_st, wait_rdy, to_q;
  logic [CNT_W-1:0] wait_cnt;

  assign wait_st  = (st_q == S_FETCH) || (st_q == S_MEM);
  assign wait_rdy = (st_q == S_FETCH) ? imem_ready : dmem_ready;
  assign to_hit   = wait_st && !wait_rdy && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Consecutive non-ready cycle count; restarts on ready and on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  wait_cnt <= '0;
    else if (st_d != st_q || !wait_st || wait_rdy) wait_cnt <= '0;
    else                                         wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      to_q <= 1'b0;
    else if (to_hit) to_q <= 1'b1;
  end

  assign timeout = to_q;
`else
  // Watchdog absent: waits are unbounded and the flag is constant 0
  assign to_hit  = 1'b0;
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle control sequencer for the sequential RV64 core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It issues the per-stage enables to the PC, instruction register, ALU, data-memory port and register file, and handshakes with the instruction and data memories. It sits beside the datapath in `processor` and replaces free-running single-cycle execution with an explicit stage FSM and a retired-instruction counter.

## Interface
- `RET_W`, 32: width of the retired-instruction counter.
- `TIMEOUT_CYCLES`, 64: watchdog limit on memory waits. Used only when `SEQ_TIMEOUT_EN` is defined.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE and begin fetching. Sampled only in IDLE.
- `opcode` in 7: `instr[6:0]` from the instruction register; valid in DECODE and later stages.
- `imem_ready` in 1: instruction word valid this cycle.
- `dmem_ready` in 1: data access complete this cycle.
- `imem_req` out 1: instruction fetch request.
- `ir_we` out 1: load instruction register.
- `alu_en` out 1: ALU operand/result capture.
- `dmem_rd` out 1: data read request.
- `dmem_wr` out 1: data write request.
- `rf_we` out 1: register-file write.
- `pc_we` out 1: PC update; this is the retire strobe.
- `state` out 3: current FSM state.
- `busy` out 1: high in any state other than IDLE or HALT.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky flag, set when an unknown opcode is decoded.
- `timeout` out 1: sticky watchdog flag. Constant 0 when `SEQ_TIMEOUT_EN` is undefined.
- `retired` out `RET_W`: count of retired instructions.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and recovers to HALT.
- Outputs are combinational decodes of the `state` register and the ready inputs. There are no other output registers except `illegal`, `timeout` and `retired`.
- IDLE: `start`=1 moves to FETCH.
- FETCH: `imem_req`=1 is held. On `imem_ready`=1, `ir_we`=1 for that cycle and the FSM moves to DECODE. Otherwise it stays in FETCH.
- DECODE: lasts one cycle and classifies `opcode`:
  - SYSTEM (1110011) moves to HALT. The instruction does not retire.
  - Any opcode outside {0110011, 0010011, 0111011, 0011011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011} sets `illegal` and moves to HALT.
  - All other legal opcodes move to EXECUTE.
- EXECUTE: `alu_en`=1 for one cycle. Next state by opcode:
  - Load or store: MEM.
  - Branch (1100011): `pc_we`=1 this cycle, then FETCH.
  - All others: WB.
- MEM: loads hold `dmem_rd`=1 and stores hold `dmem_wr`=1 until `dmem_ready`=1.
  - Load on ready: WB.
  - Store on ready: `pc_we`=1 that cycle, then FETCH.
- WB: `rf_we`=1 and `pc_we`=1 for one cycle, then FETCH.
- HALT: terminal. It is left only through `rst_n`. `start` is ignored.
- `retired` increments by 1 on every cycle with `pc_we`=1 and wraps from 2^`RET_W`-1 to 0.
- `dmem_rd` and `dmem_wr` are never high together. `rf_we` is never high outside WB.

## Timing
- Reset (async assert, synchronous release at the next posedge): `state`=IDLE, `retired`=0, `illegal`=0, `timeout`=0. All strobes, `busy` and `halted` read 0.
- Zero-wait memories give these latencies from FETCH entry to the retire strobe:
  - ALU-type: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each wait cycle on `imem_ready` or `dmem_ready` adds exactly one cycle.
- A ready input asserted while its request is low is ignored.
- `rst_n` low mid-instruction aborts the instruction immediately: strobes drop asynchronously and `retired` is not incremented.

## Configuration
- With `SEQ_TIMEOUT_EN` defined, a counter runs while in FETCH or MEM. It clears on ready and on state entry.
- If the counter reaches `TIMEOUT_CYCLES` consecutive non-ready cycles, the FSM sets `timeout` and moves to HALT. The pending access is abandoned with no strobe.
- With `SEQ_TIMEOUT_EN` undefined, there is no counter, `timeout` is tied to 0, and waits are unbounded.

## Test plan
- Reset, then `start`, then an ADD (0110011) with ready always 1: state sequence 1,2,3,5,1. `rf_we` and `pc_we` pulse in cycle 4. `retired`=1.
- LW with `dmem_ready` delayed 3 cycles: `dmem_rd` is high for 4 cycles, `rf_we` follows in the next cycle, and total latency is 8 cycles.
- SW then BEQ: SW gives `pc_we` in MEM with no `rf_we`. BEQ gives `pc_we` in EXECUTE. `retired`=2.
- Opcode 1111111: `illegal`=1, `halted`=1, `retired` unchanged. A later `start` pulse has no effect.
- Assert `rst_n`=0 during MEM with `dmem_rd` high: `dmem_rd` drops without waiting for `clk`, `state`=0, `retired`=0.
- With `SEQ_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=8 and `imem_ready` held at 0: `timeout`=1 and HALT after 8 FETCH cycles.
